// File: rtl/filter_pkg.sv
// Shared mode encodings, per-channel flag bundle and counter sizing helpers
// for the filter bank.
package filter_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT   = 2'b00,
        MODE_DEBOUNCE = 2'b01,
        MODE_STRETCH  = 2'b10,
        MODE_BOTH     = 2'b11
    } mode_e;

    typedef struct packed {
        logic out;
        logic valid;
        logic rise;
        logic fall;
    } chan_flags_t;

    // Bits needed to hold the values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/filter_channel.sv
// One filter channel: input synchronizer, tick-driven debounce and stretch
// stages, and a mode-selected registered output with edge pulses.
module filter_channel
    import filter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_HIGH_COUNT = 3,
    parameter int unsigned DEBOUNCE_LOW_COUNT  = 2,
    parameter int unsigned STRETCH_HIGH_COUNT  = 10,
    parameter int unsigned STRETCH_LOW_COUNT   = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_tick,
    input  logic        i_in,
    input  mode_e       i_mode,
    output chan_flags_t o_flags
);

    localparam int unsigned DB_W = cnt_width(max2(DEBOUNCE_HIGH_COUNT, DEBOUNCE_LOW_COUNT));
    localparam int unsigned ST_W = cnt_width(max2(STRETCH_HIGH_COUNT, STRETCH_LOW_COUNT));

    logic            r_sync1;
    logic            r_sync2;
    logic            r_db_out;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_st_out;
    logic [ST_W-1:0] r_st_hold;
    logic            r_primed;
    logic            r_out;
    logic            r_out_q;
    logic            r_valid;
    logic            r_rise;
    logic            r_fall;

    logic            w_st_in;
    logic [DB_W-1:0] w_db_cnt_inc;
    logic [DB_W-1:0] w_db_target;
    logic            w_db_accept;
    logic            w_sel_out;
    logic            w_sel_valid;

    // Stage inputs and the mode-selected output/settled flag.
    always_comb begin
        w_st_in      = r_sync2;
        w_sel_out    = r_sync2;
        w_sel_valid  = 1'b1;
        w_db_cnt_inc = r_db_cnt + DB_W'(1);
        w_db_target  = r_db_out ? DB_W'(DEBOUNCE_LOW_COUNT) : DB_W'(DEBOUNCE_HIGH_COUNT);
        w_db_accept  = (w_db_cnt_inc == w_db_target);
        case (i_mode)
            MODE_DIRECT: begin
                w_sel_out   = r_sync2;
                w_sel_valid = 1'b1;
            end
            MODE_DEBOUNCE: begin
                w_sel_out   = r_db_out;
                w_sel_valid = r_primed && (r_db_cnt == '0);
            end
            MODE_STRETCH: begin
                w_sel_out   = r_st_out;
                w_sel_valid = r_primed && (r_st_hold == '0);
            end
            MODE_BOTH: begin
                w_st_in     = r_db_out;
                w_sel_out   = r_st_out;
                w_sel_valid = r_primed && (r_db_cnt == '0) && (r_st_hold == '0);
            end
            default: begin
                w_sel_out   = r_sync2;
                w_sel_valid = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_db_out  <= 1'b0;
            r_db_cnt  <= '0;
            r_st_out  <= 1'b0;
            r_st_hold <= '0;
            r_primed  <= 1'b0;
            r_out     <= 1'b0;
            r_out_q   <= 1'b0;
            r_valid   <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_sync1 <= i_in;
            r_sync2 <= r_sync1;
            r_out   <= w_sel_out;
            r_out_q <= r_out;
            r_rise  <= r_out & ~r_out_q;
            r_fall  <= ~r_out & r_out_q;
            r_valid <= w_sel_valid;
            // Both stages advance on every tick whatever the mode.
            if (i_tick) begin
                r_primed <= 1'b1;
                if (r_sync2 != r_db_out) begin
                    if (w_db_accept) begin
                        r_db_out <= r_sync2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= w_db_cnt_inc;
                    end
                end else begin
                    r_db_cnt <= '0;
                end
                if (r_st_hold != '0) begin
                    r_st_hold <= r_st_hold - ST_W'(1);
                end else if (w_st_in != r_st_out) begin
                    r_st_out  <= w_st_in;
                    r_st_hold <= w_st_in ? ST_W'(STRETCH_HIGH_COUNT - 1)
                                         : ST_W'(STRETCH_LOW_COUNT - 1);
                end
            end
        end
    end

    // Direct mode is always settled, even while reset is held.
    always_comb begin
        o_flags.out   = r_out;
        o_flags.valid = (i_mode == MODE_DIRECT) || r_valid;
        o_flags.rise  = r_rise;
        o_flags.fall  = r_fall;
    end

endmodule

// File: rtl/filter_bank.sv
// Bank of independent input filters sharing one tick generator built from a
// cycles-per-microsecond prescaler and a microseconds-per-tick counter.
module filter_bank
    import filter_pkg::*;
#(
    parameter int unsigned CHANNELS            = 4,
    parameter int unsigned CLOCK_MHZ           = 40,
    parameter int unsigned TICK_US             = 1000,
    parameter int unsigned DEBOUNCE_HIGH_COUNT = 3,
    parameter int unsigned DEBOUNCE_LOW_COUNT  = 2,
    parameter int unsigned STRETCH_HIGH_COUNT  = 10,
    parameter int unsigned STRETCH_LOW_COUNT   = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   in,
    input  logic [2*CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0]   out,
    output logic [CHANNELS-1:0]   valid,
    output logic [CHANNELS-1:0]   rise,
    output logic [CHANNELS-1:0]   fall,
    output logic                  tick
);

    localparam int unsigned PRE_W = cnt_width(CLOCK_MHZ - 1);
    localparam int unsigned US_W  = cnt_width(TICK_US - 1);

    logic [PRE_W-1:0] r_pre;
    logic [US_W-1:0]  r_us;
    logic             r_tick;
    logic             w_us_end;
    logic             w_tick_end;

    assign w_us_end   = (r_pre == PRE_W'(CLOCK_MHZ - 1));
    assign w_tick_end = w_us_end && (r_us == US_W'(TICK_US - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pre  <= '0;
            r_us   <= '0;
            r_tick <= 1'b0;
        end else begin
            r_pre  <= w_us_end ? '0 : r_pre + PRE_W'(1);
            if (w_us_end) begin
                r_us <= w_tick_end ? '0 : r_us + US_W'(1);
            end
            r_tick <= w_tick_end;
        end
    end

    assign tick = r_tick;

    for (genvar n = 0; n < int'(CHANNELS); n++) begin : g_chan
        chan_flags_t w_flags;

        filter_channel #(
            .DEBOUNCE_HIGH_COUNT(DEBOUNCE_HIGH_COUNT),
            .DEBOUNCE_LOW_COUNT (DEBOUNCE_LOW_COUNT),
            .STRETCH_HIGH_COUNT (STRETCH_HIGH_COUNT),
            .STRETCH_LOW_COUNT  (STRETCH_LOW_COUNT)
        ) u_chan (
            .clock  (clock),
            .reset  (reset),
            .i_tick (r_tick),
            .i_in   (in[n]),
            .i_mode (mode_e'(mode[2*n +: 2])),
            .o_flags(w_flags)
        );

        assign out[n]   = w_flags.out;
        assign valid[n] = w_flags.valid;
        assign rise[n]  = w_flags.rise;
        assign fall[n]  = w_flags.fall;
    end

endmodule
